// File: rtl/wb_block_mover_if.sv
// Pipelined Wishbone bus bundle between the block mover (master) and the
// shared interconnect (slave).
interface wb_block_mover_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        stall;
  logic        ack;
  logic        err;

  modport master (
    output adr, dat_w, sel, cyc, stb, we,
    input  dat_r, stall, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, cyc, stb, we,
    output dat_r, stall, ack, err
  );
endinterface

// File: rtl/wb_block_mover.sv
// Wishbone block copier: reads a chunk of up to BURST words into a local
// buffer, releases the bus for one cycle, writes the chunk back out, repeats.
module wb_block_mover #(
  parameter int BURST = 8,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src,
  input  logic [31:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  wb_block_mover_if.master wb
);
  localparam int CW = $clog2(BURST + 1);
  localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_GAP, S_WR, S_DONE} state_t;

  state_t           r_state;
  logic             r_gap_to_wr;
  logic             r_err;
  logic [31:0]      r_src, r_dst, r_adr, r_dat_w;
  logic [LEN_W-1:0] r_rem;
  logic [CW-1:0]    r_n, r_iss_cnt, r_ack_cnt;
  logic             r_cyc, r_stb, r_we;
  logic [31:0]      r_buf [2**IW];

  logic             w_issue, w_ack, w_berr;
  logic [CW-1:0]    w_iss_nxt, w_ack_nxt;

  // Bus error wins over a coincident ack; both are ignored with cyc low.
  assign w_berr    = r_cyc && wb.err;
  assign w_ack     = r_cyc && wb.ack && !wb.err;
  assign w_issue   = r_stb && !wb.stall;
  assign w_iss_nxt = r_iss_cnt + CW'(1);
  assign w_ack_nxt = r_ack_cnt + CW'(1);

  assign wb.adr    = r_adr;
  assign wb.dat_w  = r_dat_w;
  assign wb.sel    = 4'hF;
  assign wb.cyc    = r_cyc;
  assign wb.stb    = r_stb;
  assign wb.we     = r_we;
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = done && r_err;

  function automatic logic [CW-1:0] chunk(input logic [LEN_W-1:0] rem);
    if (32'(rem) >= 32'(BURST)) return CW'(BURST);
    return CW'(rem);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gap_to_wr <= 1'b0;
      r_err       <= 1'b0;
      r_src       <= '0;
      r_dst       <= '0;
      r_adr       <= '0;
      r_dat_w     <= '0;
      r_rem       <= '0;
      r_n         <= '0;
      r_iss_cnt   <= '0;
      r_ack_cnt   <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_src     <= cmd_src & 32'hFFFF_FFFC;
          r_dst     <= cmd_dst & 32'hFFFF_FFFC;
          r_rem     <= cmd_len;
          r_n       <= chunk(cmd_len);
          r_err     <= 1'b0;
          r_iss_cnt <= '0;
          r_ack_cnt <= '0;
          if (cmd_len == '0) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_RD;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= 1'b0;
            r_adr   <= cmd_src & 32'hFFFF_FFFC;
          end
        end
        S_RD, S_WR: begin
          if (w_berr) begin
            // Abort: drop the bus, discard whatever is still in flight.
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (w_issue) begin
              r_adr     <= r_adr + 32'd4;
              r_iss_cnt <= w_iss_nxt;
              if (w_iss_nxt == r_n) r_stb <= 1'b0;
              else if (r_state == S_WR) r_dat_w <= r_buf[w_iss_nxt[IW-1:0]];
            end
            if (w_ack) begin
              if (r_state == S_RD) r_buf[r_ack_cnt[IW-1:0]] <= wb.dat_r;
              r_ack_cnt <= w_ack_nxt;
              if (w_ack_nxt == r_n) begin
                r_cyc       <= 1'b0;
                r_stb       <= 1'b0;
                r_we        <= 1'b0;
                r_iss_cnt   <= '0;
                r_ack_cnt   <= '0;
                r_gap_to_wr <= (r_state == S_RD);
                r_state     <= S_GAP;
                if (r_state == S_WR) begin
                  r_rem <= r_rem - LEN_W'(r_n);
                  r_src <= r_src + 32'({r_n, 2'b00});
                  r_dst <= r_dst + 32'({r_n, 2'b00});
                end
              end
            end
          end
        end
        S_GAP: begin
          if (r_gap_to_wr) begin
            r_state <= S_WR;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= 1'b1;
            r_adr   <= r_dst;
            r_dat_w <= r_buf[0];
          end else if (r_rem != '0) begin
            r_state <= S_RD;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= 1'b0;
            r_adr   <= r_src;
            r_n     <= chunk(r_rem);
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
